// File: rtl/kbd_painter_if.sv
// Keyboard-painter bus: PS/2 byte strobe in, framebuffer write port and status out.
// The master drives scan codes; the slave (the painter) drives everything else.
interface kbd_painter_if;
    logic        code_valid;
    logic [7:0]  code;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [2:0]  fb_data;
    logic [6:0]  cur_x;
    logic [5:0]  cur_y;
    logic [2:0]  color;
    logic        busy;

    modport master (
        output code_valid, code,
        input  fb_we, fb_addr, fb_data, cur_x, cur_y, color, busy
    );

    modport slave (
        input  code_valid, code,
        output fb_we, fb_addr, fb_data, cur_x, cur_y, color, busy
    );
endinterface

// File: rtl/kbd_painter.sv
// PS/2 set-2 decoder that moves a cursor, selects a colour and paints/clears a framebuffer.
// Optional: define KBD_PAINTER_AUTO_ADVANCE_EN to step the cursor right after each cell write.
module kbd_painter #(
    parameter int COLS = 80,
    parameter int ROWS = 60
) (
    input logic         clk,
    input logic         rst_n,
    kbd_painter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, CLEAR} state_t;

    localparam logic [6:0]  X_MAX = 7'(COLS - 1);
    localparam logic [5:0]  Y_MAX = 6'(ROWS - 1);
    localparam logic [12:0] CELLS = 13'(COLS * ROWS);

    state_t      state_q, state_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [5:0]  cur_y_q, cur_y_d;
    logic [2:0]  color_q, color_d;
    logic [12:0] clr_cnt_q, clr_cnt_d;
    logic        fb_we_q, fb_we_d;
    logic [12:0] fb_addr_q, fb_addr_d;
    logic [2:0]  fb_data_q, fb_data_d;

    logic        do_write, clr_active;
    logic [2:0]  wr_data;
    logic [12:0] clr_addr, cur_addr;

    assign cur_addr = 13'(cur_y_q) * 13'(COLS) + 13'(cur_x_q);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            color_q   <= 3'b111;
            clr_cnt_q <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            color_q   <= color_d;
            clr_cnt_q <= clr_cnt_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        color_d    = color_q;
        clr_cnt_d  = clr_cnt_q;
        do_write   = 1'b0;
        wr_data    = '0;
        clr_active = 1'b0;
        clr_addr   = '0;

        unique case (state_q)
            IDLE: if (bus.code_valid) begin
                case (bus.code)
                    8'hE0: state_d = EXT;
                    8'hF0: state_d = BRK;
                    8'h45: color_d = 3'd0;
                    8'h16: color_d = 3'd1;
                    8'h1E: color_d = 3'd2;
                    8'h26: color_d = 3'd3;
                    8'h25: color_d = 3'd4;
                    8'h2E: color_d = 3'd5;
                    8'h36: color_d = 3'd6;
                    8'h3D: color_d = 3'd7;
                    8'h29: begin do_write = 1'b1; wr_data = color_q; end
                    8'h66: begin do_write = 1'b1; wr_data = '0;      end
                    8'h21: begin
                        state_d    = CLEAR;
                        clr_active = 1'b1;
                        clr_cnt_d  = 13'd1;
                    end
                    default: ;
                endcase
            end
            EXT: if (bus.code_valid) begin
                state_d = (bus.code == 8'hF0) ? EXTBRK : IDLE;
                case (bus.code)
                    8'h75: cur_y_d = (cur_y_q == '0)    ? Y_MAX : cur_y_q - 6'd1;
                    8'h72: cur_y_d = (cur_y_q == Y_MAX) ? '0    : cur_y_q + 6'd1;
                    8'h6B: cur_x_d = (cur_x_q == '0)    ? X_MAX : cur_x_q - 7'd1;
                    8'h74: cur_x_d = (cur_x_q == X_MAX) ? '0    : cur_x_q + 7'd1;
                    default: ;
                endcase
            end
            BRK, EXTBRK: if (bus.code_valid) state_d = IDLE;
            CLEAR: begin
                // Incoming bytes are ignored here; leaving CLEAR always lands in a clean IDLE.
                if (clr_cnt_q == CELLS) begin
                    state_d = IDLE;
                end else begin
                    clr_active = 1'b1;
                    clr_addr   = clr_cnt_q;
                    clr_cnt_d  = clr_cnt_q + 13'd1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef KBD_PAINTER_AUTO_ADVANCE_EN
        if (do_write) begin
            if (cur_x_q == X_MAX) begin
                cur_x_d = '0;
                cur_y_d = (cur_y_q == Y_MAX) ? '0 : cur_y_q + 6'd1;
            end else begin
                cur_x_d = cur_x_q + 7'd1;
            end
        end
`endif

        // Write address is the pre-move cursor; otherwise the port tracks the next cursor cell.
        fb_we_d   = do_write | clr_active;
        fb_data_d = do_write ? wr_data : '0;
        if (do_write)        fb_addr_d = cur_addr;
        else if (clr_active) fb_addr_d = clr_addr;
        else                 fb_addr_d = 13'(cur_y_d) * 13'(COLS) + 13'(cur_x_d);
    end

    assign bus.fb_we   = fb_we_q;
    assign bus.fb_addr = fb_addr_q;
    assign bus.fb_data = fb_data_q;
    assign bus.cur_x   = cur_x_q;
    assign bus.cur_y   = cur_y_q;
    assign bus.color   = color_q;
    assign bus.busy    = (state_q == CLEAR);
endmodule

// File: tb/tb_kbd_painter.sv
// Self-checking bench for kbd_painter: directed vector table, clear/reset sequences,
// and randomized scan-code traffic against a prefix-queue reference model.
module tb_kbd_painter;
    localparam int COLS = 80;
    localparam int ROWS = 60;
`ifdef KBD_PAINTER_AUTO_ADVANCE_EN
    localparam int ADV = 1;
`else
    localparam int ADV = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    kbd_painter_if bus ();

    kbd_painter #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] code;
        bit         we;
        int         addr;
        int         data;
        int         x;
        int         y;
        int         col;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit v, logic [7:0] code, bit we, int data,
                                int addr, int x, int y, int col);
        vec_t r;
        r.rst = rst; r.v = v; r.code = code; r.we = we; r.data = data;
        r.addr = addr; r.x = x; r.y = y; r.col = col;
        return r;
    endfunction

    // Idle-port address of cursor (x,y) in the table below.
    function automatic int ca(int x, int y);
        return y * COLS + x;
    endfunction

    task automatic cycle(input bit v, input logic [7:0] c);
        bus.code_valid = v;
        bus.code       = c;
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
    endtask

    task automatic check_all(input string tag, input int we, input int addr, input int data,
                             input int x, input int y, input int col, input int busy);
        check({tag, ".fb_we"},   32'(bus.fb_we),   32'(we));
        check({tag, ".fb_addr"}, 32'(bus.fb_addr), 32'(addr));
        check({tag, ".fb_data"}, 32'(bus.fb_data), 32'(data));
        check({tag, ".cur_x"},   32'(bus.cur_x),   32'(x));
        check({tag, ".cur_y"},   32'(bus.cur_y),   32'(y));
        check({tag, ".color"},   32'(bus.color),   32'(col));
        check({tag, ".busy"},    32'(bus.busy),    32'(busy));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    // Reference model: prefix bytes held in a queue, cursor as plain integers.
    int         mx, my, mcol;
    logic [7:0] pend[$];

    task automatic model_step(input bit v, input logic [7:0] b,
                              output int we, output int addr, output int data);
        bit ext;
        we = 0; data = 0; addr = 0;
        if (v) begin
            if (pend.size() > 0 && pend[pend.size()-1] == 8'hF0) begin
                pend.delete();
            end else if (b == 8'hF0 || (b == 8'hE0 && pend.size() == 0)) begin
                pend.push_back(b);
            end else begin
                ext = (pend.size() > 0);
                pend.delete();
                if (ext) begin
                    case (b)
                        8'h75: my = (my + ROWS - 1) % ROWS;
                        8'h72: my = (my + 1) % ROWS;
                        8'h6B: mx = (mx + COLS - 1) % COLS;
                        8'h74: mx = (mx + 1) % COLS;
                        default: ;
                    endcase
                end else begin
                    case (b)
                        8'h45: mcol = 0; 8'h16: mcol = 1; 8'h1E: mcol = 2; 8'h26: mcol = 3;
                        8'h25: mcol = 4; 8'h2E: mcol = 5; 8'h36: mcol = 6; 8'h3D: mcol = 7;
                        8'h29, 8'h66: begin
                            we   = 1;
                            data = (b == 8'h29) ? mcol : 0;
                            addr = my * COLS + mx;
                            if (ADV != 0) begin
                                mx = mx + 1;
                                if (mx == COLS) begin mx = 0; my = (my + 1) % ROWS; end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
        if (we == 0) addr = my * COLS + mx;
    endtask

    logic [7:0] pool [19] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h45, 8'h16, 8'h1E,
                             8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h29, 8'h66, 8'h5A, 8'h1C, 8'h00};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;

        // ---------------- directed vector table ----------------
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 7));
        for (int i = 1; i <= 3; i++) begin
            vecs.push_back(mk(0, 1, 8'hE0, 0, 0, ca(i-1, 0), i-1, 0, 7));
            vecs.push_back(mk(0, 1, 8'h74, 0, 0, ca(i, 0),   i,   0, 7));
        end
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 7));
        vecs.push_back(mk(0, 1, 8'hE0, 0, 0, 0,            0,  0,  7));
        vecs.push_back(mk(0, 1, 8'h6B, 0, 0, ca(79, 0),    79, 0,  7));
        vecs.push_back(mk(0, 1, 8'hE0, 0, 0, ca(79, 0),    79, 0,  7));
        vecs.push_back(mk(0, 1, 8'h75, 0, 0, 4799,         79, 59, 7));
        vecs.push_back(mk(0, 1, 8'hE0, 0, 0, 4799,         79, 59, 7));
        vecs.push_back(mk(0, 1, 8'h72, 0, 0, ca(79, 0),    79, 0,  7));
        vecs.push_back(mk(0, 1, 8'hE0, 0, 0, ca(79, 0),    79, 0,  7));
        vecs.push_back(mk(0, 1, 8'h74, 0, 0, 0,            0,  0,  7));
        for (int j = 1; j <= 2; j++) begin
            vecs.push_back(mk(0, 1, 8'hE0, 0, 0, ca(0, j-1), 0, j-1, 7));
            vecs.push_back(mk(0, 1, 8'h72, 0, 0, ca(0, j),   0, j,   7));
        end
        for (int i = 1; i <= 5; i++) begin
            vecs.push_back(mk(0, 1, 8'hE0, 0, 0, ca(i-1, 2), i-1, 2, 7));
            vecs.push_back(mk(0, 1, 8'h74, 0, 0, ca(i, 2),   i,   2, 7));
        end
        vecs.push_back(mk(0, 1, 8'h1E, 0, 0, 165, 5, 2, 2));
        vecs.push_back(mk(0, 1, 8'h29, 1, 2, 165, 5+ADV, 2, 2));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, ca(5+ADV, 2), 5+ADV, 2, 2));
        vecs.push_back(mk(0, 1, 8'hF0, 0, 0, ca(5+ADV, 2), 5+ADV, 2, 2));
        vecs.push_back(mk(0, 1, 8'h29, 0, 0, ca(5+ADV, 2), 5+ADV, 2, 2));
        vecs.push_back(mk(0, 1, 8'h29, 1, 2, ca(5+ADV, 2), 5+2*ADV, 2, 2));
        vecs.push_back(mk(0, 1, 8'h66, 1, 0, ca(5+2*ADV, 2), 5+3*ADV, 2, 2));
        vecs.push_back(mk(0, 1, 8'hE0, 0, 0, ca(5+3*ADV, 2), 5+3*ADV, 2, 2));
        vecs.push_back(mk(0, 1, 8'hF0, 0, 0, ca(5+3*ADV, 2), 5+3*ADV, 2, 2));
        vecs.push_back(mk(0, 1, 8'h75, 0, 0, ca(5+3*ADV, 2), 5+3*ADV, 2, 2));
        vecs.push_back(mk(0, 1, 8'h45, 0, 0, ca(5+3*ADV, 2), 5+3*ADV, 2, 0));
        vecs.push_back(mk(0, 1, 8'h5A, 0, 0, ca(5+3*ADV, 2), 5+3*ADV, 2, 0));
        vecs.push_back(mk(0, 1, 8'hE0, 0, 0, ca(5+3*ADV, 2), 5+3*ADV, 2, 0));
        vecs.push_back(mk(0, 1, 8'h1C, 0, 0, ca(5+3*ADV, 2), 5+3*ADV, 2, 0));
        vecs.push_back(mk(0, 1, 8'h29, 1, 0, ca(5+3*ADV, 2), 5+4*ADV, 2, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            rst_n = !vecs[k].rst;
            cycle(vecs[k].v, vecs[k].code);
            rst_n = 1'b1;
            check_all($sformatf("vec%0d", k), int'(vecs[k].we), vecs[k].addr, vecs[k].data,
                      vecs[k].x, vecs[k].y, vecs[k].col, 0);
        end

        // ---------------- full clear sweep ----------------
        begin
            int n, errs, x0, y0, c0;
            x0 = int'(bus.cur_x); y0 = int'(bus.cur_y); c0 = int'(bus.color);
            cycle(1'b1, 8'h21);
            n = 0; errs = 0;
            while (bus.busy === 1'b1 && n < 6000) begin
                if (bus.fb_we !== 1'b1 || bus.fb_data !== 3'd0 || int'(bus.fb_addr) != n ||
                    int'(bus.cur_x) != x0 || int'(bus.cur_y) != y0 || int'(bus.color) != c0)
                    errs++;
                n++;
                if (n == 100)      cycle(1'b1, 8'h29);
                else if (n == 200) cycle(1'b1, 8'hE0);
                else               cycle(1'b0, 8'h00);
            end
            check("clear.busy_cycles", 32'(n), 32'd4800);
            check("clear.bad_cycles", 32'(errs), 32'd0);
            check_all("clear.after", 0, ca(x0, y0), 0, x0, y0, c0, 0);
            cycle(1'b1, 8'h74);
            check_all("clear.no_prefix", 0, ca(x0, y0), 0, x0, y0, c0, 0);
        end

        // ---------------- reset mid-sweep ----------------
        begin
            int extra;
            cycle(1'b1, 8'h21);
            check("abort.busy_start", 32'(bus.busy), 32'd1);
            repeat (50) cycle(1'b0, 8'h00);
            rst_n = 1'b0;
            cycle(1'b0, 8'h00);
            rst_n = 1'b1;
            check_all("abort.reset", 0, 0, 0, 0, 0, 7, 0);
            extra = 0;
            for (int i = 0; i < 20; i++) begin
                cycle(1'b0, 8'h00);
                if (bus.fb_we !== 1'b0 || bus.busy !== 1'b0) extra++;
            end
            check("abort.no_writes", 32'(extra), 32'd0);
        end

`ifdef KBD_PAINTER_AUTO_ADVANCE_EN
        // ---------------- auto-advance wrap at last cell ----------------
        do_reset();
        cycle(1'b1, 8'hE0); cycle(1'b1, 8'h6B);
        cycle(1'b1, 8'hE0); cycle(1'b1, 8'h75);
        check_all("adv.at_corner", 0, 4799, 0, 79, 59, 7, 0);
        cycle(1'b1, 8'h29);
        check_all("adv.write", 1, 4799, 7, 0, 0, 7, 0);
        cycle(1'b0, 8'h00);
        check_all("adv.idle", 0, 0, 0, 0, 0, 7, 0);
`endif

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        mx = 0; my = 0; mcol = 7; pend.delete();
        for (int i = 0; i < 600; i++) begin
            bit         v;
            logic [7:0] b;
            int         ew, ea, ed;
            v = ($urandom_range(0, 9) < 7);
            b = pool[$urandom_range(0, 18)];
            cycle(v, b);
            model_step(v, b, ew, ea, ed);
            check_all($sformatf("rand%0d", i), ew, ea, ed, mx, my, mcol, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
